// File: rtl/dcpu_pkg.sv
// ---------------------------------------------------------------------------
// dcpu_pkg : shared fetch-unit constants, FSM state codes and helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dcpu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  localparam int unsigned DEF_RESET_VEC = 'h0000;
  localparam int unsigned DEF_INT_VEC   = 'h0010;

  function automatic int unsigned npw(input int unsigned dw, input int unsigned iw);
    return dw / iw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcpu_fetch_fifo.sv
// ---------------------------------------------------------------------------
// dcpu_fetch_fifo : {pc,insn} prefetch queue, multi-push from one bus word
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcpu_fetch_fifo
  import dcpu_pkg::*;
#(
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 32,
  parameter int unsigned IW    = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [CW-1:0] push_off,
  input  logic [DW-1:0] push_word,
  input  logic [AW-1:0] push_addr,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          head_valid,
  output logic [IW-1:0] head_insn,
  output logic [AW-1:0] head_pc,
  output logic [AW-1:0] next_head_pc
);

  localparam int unsigned NPW = npw(DW, IW);
  localparam int unsigned BPI = IW / 8;
  localparam int unsigned PW  = $clog2(DEPTH);

  logic [IW-1:0] insn_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] push_n;
  logic          pop_fire;

  assign pop_fire = pop && (cnt != '0);
  assign push_n   = push ? (CW'(NPW) - push_off) : '0;

  // Instruction j of the word lands in slot wr_ptr + (j - push_off); the slots
  // below push_off belong to addresses before the fetch PC and are skipped.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        for (int j = 0; j < NPW; j++) begin
          if (CW'(j) >= push_off) begin
            insn_mem[wr_ptr + PW'(CW'(j) - push_off)] <= push_word[j*IW +: IW];
            pc_mem[wr_ptr + PW'(CW'(j) - push_off)]   <= push_addr + AW'(j * BPI);
          end
        end
      end
      rd_ptr <= rd_ptr + PW'(pop_fire);
      wr_ptr <= wr_ptr + PW'(push_n);
      cnt    <= cnt - CW'(pop_fire) + push_n;
    end
  end

  assign count        = cnt;
  assign head_valid   = (cnt != '0);
  assign head_insn    = insn_mem[rd_ptr];
  assign head_pc      = pc_mem[rd_ptr];
  assign next_head_pc = pc_mem[rd_ptr + PW'(pop_fire)];

endmodule

`default_nettype wire

// File: rtl/dcpu_fetch.sv
// ---------------------------------------------------------------------------
// dcpu_fetch : Wishbone-classic instruction fetch with prefetch queue
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcpu_fetch
  import dcpu_pkg::*;
#(
  parameter int unsigned   AW        = 16,
  parameter int unsigned   DW        = 32,
  parameter int unsigned   IW        = 16,
  parameter int unsigned   DEPTH     = 4,
  parameter logic [AW-1:0] RESET_VEC = AW'(DEF_RESET_VEC),
  parameter logic [AW-1:0] INT_VEC   = AW'(DEF_INT_VEC)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic            o_cyc,
  output logic [DW/8-1:0] o_stb,
  output logic            o_we,
  output logic [DW-1:0]   o_dat,
  output logic [AW-1:0]   o_addr,
  input  logic            i_ack,
  input  logic [DW-1:0]   i_dat,
  output logic            o_insn_valid,
  output logic [IW-1:0]   o_insn,
  output logic [AW-1:0]   o_insn_pc,
  input  logic            i_insn_ready,
  input  logic            i_redirect,
  input  logic [AW-1:0]   i_redirect_pc,
  input  logic            i_int,
  input  logic            i_inten,
  output logic            o_int_ack,
  output logic [AW-1:0]   o_int_ret_pc
);

  localparam int unsigned NPW = npw(DW, IW);
  localparam int unsigned BPW = DW / 8;
  localparam int unsigned BPI = IW / 8;
  localparam int unsigned IBL = $clog2(BPI);
  localparam int unsigned CW  = $clog2(DEPTH) + 1;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW-1:0] fpc;
  logic [AW-1:0] fpc_off;
  logic [AW-1:0] fetch_addr;
  logic [AW-1:0] next_head_pc;
  logic [AW-1:0] int_ret_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] word_off;
  logic [CW-1:0] push_n;
  logic [CW-1:0] count_post_pop;
  logic [CW-1:0] count_post;
  logic          room;
  logic          pop;
  logic          push;
  logic          take_int;
  logic          flush;
  logic          int_ack;

  assign fpc_off    = fpc & AW'(BPW - 1);
  assign fetch_addr = fpc - fpc_off;
  assign word_off   = CW'(fpc_off >> IBL);

  assign take_int = i_int && i_inten && !i_redirect && !int_ack;
  assign flush    = i_redirect || take_int;
  assign pop      = o_insn_valid && i_insn_ready;
  assign push     = (state == ST_REQ) && i_ack && !flush;

  // Room for a whole word is judged on the occupancy after this cycle's pop and push.
  assign push_n         = push ? (CW'(NPW) - word_off) : '0;
  assign count_post_pop = count - CW'(pop);
  assign count_post     = count_post_pop + push_n;
  assign room           = (CW'(DEPTH) - count_post) >= CW'(NPW);

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = (state == ST_REQ) ? ST_ABORT : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (room) state_nxt = ST_REQ;
        ST_REQ:   if (i_ack) state_nxt = room ? ST_REQ : ST_IDLE;
        ST_ABORT: state_nxt = room ? ST_REQ : ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_cyc = (state == ST_REQ);
    o_stb = {BPW{o_cyc}};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fpc        <= RESET_VEC;
      int_ack    <= 1'b0;
      int_ret_pc <= '0;
    end else begin
      int_ack <= take_int;
      if (take_int) int_ret_pc <= (count_post_pop != '0) ? next_head_pc : fpc;
      if (i_redirect)    fpc <= i_redirect_pc & ~AW'(BPI - 1);
      else if (take_int) fpc <= INT_VEC;
      else if (push)     fpc <= fetch_addr + AW'(BPW);
    end
  end

  assign o_we         = 1'b0;
  assign o_dat        = '0;
  assign o_addr       = fetch_addr;
  assign o_int_ack    = int_ack;
  assign o_int_ret_pc = int_ret_pc;

  dcpu_fetch_fifo #(
    .AW    (AW),
    .DW    (DW),
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (i_clk),
    .rst          (i_reset),
    .flush        (flush),
    .push         (push),
    .push_off     (word_off),
    .push_word    (i_dat),
    .push_addr    (fetch_addr),
    .pop          (pop),
    .count        (count),
    .head_valid   (o_insn_valid),
    .head_insn    (o_insn),
    .head_pc      (o_insn_pc),
    .next_head_pc (next_head_pc)
  );

endmodule

`default_nettype wire

// File: tb/tb_dcpu_fetch.sv
// ---------------------------------------------------------------------------
// tb_dcpu_fetch : directed scenarios plus randomized run against a stream model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dcpu_fetch;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 16;
  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] RV = 16'h0000;
  localparam logic [15:0] IV = 16'h0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc;
  logic [3:0]  stb;
  logic        we;
  logic [31:0] dat_o;
  logic [15:0] addr;
  logic        ack = 1'b0;
  logic [31:0] dat_i = '0;
  logic        valid;
  logic [15:0] insn;
  logic [15:0] insn_pc;
  logic        ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        irq = 1'b0;
  logic        inten = 1'b0;
  logic        int_ack;
  logic [15:0] int_ret_pc;

  int n_cmp = 0;
  int n_bad = 0;

  dcpu_fetch #(
    .AW(AW), .DW(DW), .IW(IW), .DEPTH(DEPTH), .RESET_VEC(RV), .INT_VEC(IV)
  ) dut (
    .i_clk(clk), .i_reset(rst), .o_cyc(cyc), .o_stb(stb), .o_we(we), .o_dat(dat_o),
    .o_addr(addr), .i_ack(ack), .i_dat(dat_i), .o_insn_valid(valid), .o_insn(insn),
    .o_insn_pc(insn_pc), .i_insn_ready(ready), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .i_int(irq), .i_inten(inten), .o_int_ack(int_ack),
    .o_int_ret_pc(int_ret_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory image: every halfword address holds a distinct instruction.
  function automatic logic [15:0] insn_at(input logic [15:0] pc);
    logic [15:0] p;
    p = pc * 16'h9E37;
    return p ^ 16'hC3A5;
  endfunction

  function automatic logic [31:0] word_at(input logic [15:0] a);
    return {insn_at(a + 16'd2), insn_at(a)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [15:0] pc);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_pc"}, insn_pc, pc);
    check({tag, "_insn"}, insn, insn_at(pc));
  endtask

  logic [15:0] wrap_pcs [3];
  logic [15:0] exp_pc;
  logic [15:0] exp_ret;
  logic        exp_ack;
  logic        exp_ack_n;
  logic        exp_empty;
  logic        take;
  int          pops;

  initial begin
    wrap_pcs = '{16'hFFFC, 16'hFFFE, 16'h0000};

    // Reset state and first fetches
    step(); step();
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_valid", valid, 0);
    check("rst_int_ack", int_ack, 0);
    rst = 1'b0;
    step();
    check("first_cyc", cyc, 1);
    check("first_addr", addr, 16'h0000);
    ack = 1'b1; dat_i = word_at(16'h0000);
    step();
    check("t1_addr4", addr, 16'h0004);
    check("t1_cyc", cyc, 1);
    check_head("t1_head0", 16'h0000);
    dat_i = word_at(16'h0004);
    step();
    // Queue full, no reader: bus must stay idle
    check("t2_full_cyc", cyc, 0);
    ack = 1'b0;
    step(); step();
    check("t2_idle_cyc", cyc, 0);
    check_head("t2_head", 16'h0000);
    ready = 1'b1;
    step();
    check("t2_one_free_cyc", cyc, 0);
    check_head("t2_pop1", 16'h0002);
    step();
    ready = 1'b0;
    check("t2_two_free_cyc", cyc, 1);
    check("t2_addr8", addr, 16'h0008);
    check_head("t2_pop2", 16'h0004);

    // Redirect with a cycle outstanding
    redirect = 1'b1; redirect_pc = 16'h0006;
    step();
    redirect = 1'b0;
    check("t3_abort_cyc", cyc, 0);
    check("t3_flush_valid", valid, 0);
    step();
    check("t3_refetch_cyc", cyc, 1);
    check("t3_refetch_addr", addr, 16'h0004);
    ack = 1'b1; dat_i = word_at(16'h0004);
    step();
    ack = 1'b0;
    check_head("t3_head", 16'h0006);
    check("t3_next_addr", addr, 16'h0008);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("t3_single", valid, 0);

    // Ack coinciding with redirect is dropped
    ack = 1'b1; dat_i = word_at(16'h0008);
    redirect = 1'b1; redirect_pc = 16'h0030;
    step();
    ack = 1'b0; redirect = 1'b0;
    check("t4_cyc", cyc, 0);
    check("t4_valid", valid, 0);
    step();
    check("t4_addr", addr, 16'h0030);
    ack = 1'b1; dat_i = word_at(16'h0030);
    step();
    ack = 1'b0;
    check_head("t4_head", 16'h0030);

    // Interrupt entry
    redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    step();
    check("t5_addr", addr, 16'h0020);
    ack = 1'b1; dat_i = word_at(16'h0020);
    step();
    ack = 1'b0;
    check_head("t5_head", 16'h0020);
    irq = 1'b1; inten = 1'b0;
    step();
    check("t5_masked", int_ack, 0);
    inten = 1'b1;
    step();
    check("t5_ack", int_ack, 1);
    check("t5_ret_pc", int_ret_pc, 16'h0020);
    check("t5_flush", valid, 0);
    step();
    irq = 1'b0; inten = 1'b0;
    check("t5_pulse", int_ack, 0);
    check("t5_vec_cyc", cyc, 1);
    check("t5_vec_addr", addr, IV);

    // Address wrap-around
    redirect = 1'b1; redirect_pc = 16'hFFFC;
    step();
    redirect = 1'b0;
    step();
    check("t6_addr_top", addr, 16'hFFFC);
    ack = 1'b1; dat_i = word_at(16'hFFFC);
    step();
    check("t6_addr_wrap", addr, 16'h0000);
    dat_i = word_at(16'h0000);
    step();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_head("t6_wrap", wrap_pcs[i]);
      ready = 1'b1;
      step();
    end
    ready = 1'b0;

    // Randomized run: the decoder must see the sequential stream from the
    // last redirect / vector / reset target, whatever the bus timing.
    exp_pc = 16'h0002;
    exp_ack = 1'b0;
    exp_ret = '0;
    exp_empty = 1'b0;
    pops = 0;
    for (int i = 0; i < 4000; i++) begin
      check("r_int_ack", int_ack, exp_ack);
      if (exp_ack) check("r_ret_pc", int_ret_pc, exp_ret);
      check("r_stb", stb, {4{cyc}});
      if (cyc) check("r_addr_align", addr[1:0], 0);
      if (exp_empty) begin
        check("r_rst_valid", valid, 0);
        check("r_rst_cyc", cyc, 0);
      end
      if (valid) begin
        check("r_head_pc", insn_pc, exp_pc);
        check("r_head_insn", insn, insn_at(exp_pc));
      end

      rst = ($urandom_range(0, 399) == 0);
      ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 29) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                                : 16'($urandom);
      irq = ($urandom_range(0, 19) == 0);
      inten = ($urandom_range(0, 1) == 1);
      if (cyc) begin
        ack = ($urandom_range(0, 2) != 0);
        dat_i = word_at(addr);
      end else begin
        ack = ($urandom_range(0, 7) == 0);
        dat_i = $urandom;
      end

      if (rst) begin
        exp_pc = RV;
        exp_ack_n = 1'b0;
      end else begin
        if (valid && ready) begin
          exp_pc = exp_pc + 16'd2;
          pops++;
        end
        take = irq && inten && !redirect && !exp_ack;
        exp_ack_n = take;
        if (redirect) begin
          exp_pc = redirect_pc & 16'hFFFE;
        end else if (take) begin
          exp_ret = exp_pc;
          exp_pc = IV;
        end
      end
      exp_empty = rst;
      step();
      exp_ack = exp_ack_n;
    end
    check("r_progress", (pops >= 400), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
